wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the CDB_WIDTH complete-stage writeback slots between NUM_FU functional-unit result ports and the single LSQ load-writeback port.
- Sits between FU outputs / LSQ and complete_stage. Its registered slot outputs drive complete_stage's fu_* inputs directly, so complete_stage no longer needs its per-slot LSQ fallback path.
- Grants FUs round-robin with valid/ready backpressure. Load results are buffered in a small FIFO that is drained opportunistically, or forcibly when the FIFO is full.

Parameters:
- NUM_FU, 6, number of FU result requesters
- CDB_WIDTH, 4, writeback slots per cycle (must be <= NUM_FU+1)
- XLEN, 32, data width
- PHYS_REGS, 128, physical registers; tag width is $clog2(PHYS_REGS)
- ROB_DEPTH, 64, ROB entries; index width is $clog2(ROB_DEPTH)
- LD_BUF_DEPTH, 4, load FIFO entries (power of two, >= 2)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  mispredict squash
- fu_valid_i  in  NUM_FU  FU result request
- fu_ready_o  out  NUM_FU  grant; a transfer occurs when valid & ready
- fu_value_i  in  NUM_FU x XLEN  result value
- fu_dest_prf_i  in  NUM_FU x $clog2(PHYS_REGS)  destination physical tag
- fu_rob_idx_i  in  NUM_FU x $clog2(ROB_DEPTH)  ROB index
- fu_exception_i  in  NUM_FU  exception flag
- fu_mispred_i  in  NUM_FU  mispredict flag
- ld_valid_i  in  1  LSQ load writeback
- ld_ready_o  out  1  load FIFO not full
- ld_data_i  in  XLEN  load data
- ld_dest_prf_i  in  $clog2(PHYS_REGS)  load destination tag
- ld_rob_idx_i  in  $clog2(ROB_DEPTH)  load ROB index
- slot_valid_o  out  CDB_WIDTH  registered slot valid
- slot_value_o  out  CDB_WIDTH x XLEN  slot value
- slot_dest_prf_o  out  CDB_WIDTH x $clog2(PHYS_REGS)  slot destination tag
- slot_rob_idx_o  out  CDB_WIDTH x $clog2(ROB_DEPTH)  slot ROB index
- slot_exception_o  out  CDB_WIDTH  slot exception flag (always 0 for loads)
- slot_mispred_o  out  CDB_WIDTH  slot mispredict flag (always 0 for loads)
- ld_buf_count_o  out  $clog2(LD_BUF_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all slot_* = 0, rr_ptr = 0, FIFO empty, count = 0, ld_ready_o = 1. fu_ready_o = 0 while reset is high.
- Load FIFO: ld_ready_o = (count != LD_BUF_DEPTH), independent of same-cycle pop.
  - Push when ld_valid_i & ld_ready_o.
  - Loads always pass through the FIFO; there is no same-cycle bypass.
  - Pointers wrap modulo LD_BUF_DEPTH. Simultaneous push and pop leave count unchanged.
- Per-cycle arbitration (combinational):
  - Urgent mode, when count == LD_BUF_DEPTH: the FIFO head takes slot 0, then FUs fill slots 1..CDB_WIDTH-1.
  - Normal mode: FUs fill slots from slot 0.
  - FU order: scan indices rr_ptr, rr_ptr+1, … mod NUM_FU; grant valid FUs in that order until slots run out.
  - Normal mode, after FUs: if any slot remains and count != 0, the FIFO head takes the next free slot and is popped.
  - At most one load is granted per cycle.
  - fu_ready_o[i] = 1 only for granted FUs; it depends combinationally on fu_valid_i.
- rr_ptr update: (index of last granted FU + 1) mod NUM_FU; unchanged if no FU is granted.
- Output latency: granted data is registered; slot_* reflect grants made in cycle t at cycle t+1.
  - Granted entries fill slots contiguously from slot 0 in grant order.
  - Unused slots output all zeros.
  - Load latency: push at t, earliest grant at t+1, visible at t+2.
- Flush (flush_i = 1 in cycle t):
  - No grants in cycle t: fu_ready_o = 0 and ld_ready_o = 0 (no push).
  - At t+1, FIFO is empty and all slot_* = 0.
  - rr_ptr is preserved.
  - Flush has priority over all other events except reset.
- Reset asserted mid-traffic discards FIFO contents and registered slots on the next edge.

Test Plan:
- Reset → slot_valid_o=0000, ld_ready_o=1, ld_buf_count_o=0, fu_ready_o=000000.
- fu_valid_i=111111 held, rr_ptr=0:
  - cycle 0: fu_ready_o=001111; next cycle slots carry FU0..FU3.
  - cycle 1: grants FU4, FU5, FU0, FU1 (wrap); rr_ptr becomes 2.
- fu_valid_i=000011, one load in FIFO → FU0 in slot 0, FU1 in slot 1, load in slot 2; slot_valid_o=0111 next cycle; count 1→0.
- fu_valid_i=111111 saturating, ld_valid_i=1 for 5 consecutive cycles:
  - count climbs 1,2,3,4; ld_ready_o=0 at count 4.
  - Urgent mode puts the load head in slot 0 with only 3 FU grants; count returns to 3.
- Load FIFO holding 3 entries, FUs active, flush_i=1 for one cycle → fu_ready_o=0 that cycle; next cycle count=0, slot_valid_o=0000, rr_ptr unchanged.
- Single load (ld_rob_idx_i=5, ld_dest_prf_i=40, ld_data_i=32'hDEADBEEF), FUs idle → at t+2: slot 0 valid, rob 5, tag 40, value DEADBEEF, exception=0, mispred=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares CDB_WIDTH complete-stage slots between NUM_FU result ports
// and a FIFO-buffered LSQ load port, with round-robin FU grants and registered slot outputs.
module wb_arbiter #(
  parameter int unsigned NUM_FU       = 6,
  parameter int unsigned CDB_WIDTH    = 4,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PHYS_REGS    = 128,
  parameter int unsigned ROB_DEPTH    = 64,
  parameter int unsigned LD_BUF_DEPTH = 4,
  localparam int unsigned TagW     = $clog2(PHYS_REGS),
  localparam int unsigned RobW     = $clog2(ROB_DEPTH),
  localparam int unsigned PtrW     = $clog2(LD_BUF_DEPTH),
  localparam int unsigned CntW     = PtrW + 1,
  localparam int unsigned FuIdxW   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int unsigned SlotIdxW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic [NUM_FU-1:0]                   fu_valid_i,
  output logic [NUM_FU-1:0]                   fu_ready_o,
  input  logic [NUM_FU-1:0][XLEN-1:0]         fu_value_i,
  input  logic [NUM_FU-1:0][TagW-1:0]         fu_dest_prf_i,
  input  logic [NUM_FU-1:0][RobW-1:0]         fu_rob_idx_i,
  input  logic [NUM_FU-1:0]                   fu_exception_i,
  input  logic [NUM_FU-1:0]                   fu_mispred_i,
  input  logic                                ld_valid_i,
  output logic                                ld_ready_o,
  input  logic [XLEN-1:0]                     ld_data_i,
  input  logic [TagW-1:0]                     ld_dest_prf_i,
  input  logic [RobW-1:0]                     ld_rob_idx_i,
  output logic [CDB_WIDTH-1:0]                slot_valid_o,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]      slot_value_o,
  output logic [CDB_WIDTH-1:0][TagW-1:0]      slot_dest_prf_o,
  output logic [CDB_WIDTH-1:0][RobW-1:0]      slot_rob_idx_o,
  output logic [CDB_WIDTH-1:0]                slot_exception_o,
  output logic [CDB_WIDTH-1:0]                slot_mispred_o,
  output logic [CntW-1:0]                     ld_buf_count_o
);

  logic [XLEN-1:0] buf_data [LD_BUF_DEPTH];
  logic [TagW-1:0] buf_dest [LD_BUF_DEPTH];
  logic [RobW-1:0] buf_rob  [LD_BUF_DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [FuIdxW-1:0] rr_ptr_q, rr_ptr_d;

  logic [CDB_WIDTH-1:0]            slot_valid_d, slot_valid_q;
  logic [CDB_WIDTH-1:0][XLEN-1:0]  slot_value_d, slot_value_q;
  logic [CDB_WIDTH-1:0][TagW-1:0]  slot_dest_d, slot_dest_q;
  logic [CDB_WIDTH-1:0][RobW-1:0]  slot_rob_d, slot_rob_q;
  logic [CDB_WIDTH-1:0]            slot_exc_d, slot_exc_q;
  logic [CDB_WIDTH-1:0]            slot_mis_d, slot_mis_q;

  logic full;
  logic ld_push;
  logic ld_pop;

  assign full       = (count_q == CntW'(LD_BUF_DEPTH));
  assign ld_ready_o = ~flush_i & ~full;
  assign ld_push    = ld_valid_i & ld_ready_o & ~reset;

  always_comb begin
    int unsigned       n;
    int unsigned       idx;
    logic              any_fu;
    logic [FuIdxW-1:0] last_fu;
    n            = 0;
    idx          = 0;
    any_fu       = 1'b0;
    last_fu      = '0;
    fu_ready_o   = '0;
    ld_pop       = 1'b0;
    slot_valid_d = '0;
    slot_value_d = '0;
    slot_dest_d  = '0;
    slot_rob_d   = '0;
    slot_exc_d   = '0;
    slot_mis_d   = '0;
    if (!reset && !flush_i) begin
      // A full FIFO forces its head into slot 0 ahead of any FU.
      if (full) begin
        slot_valid_d[0] = 1'b1;
        slot_value_d[0] = buf_data[rd_ptr_q];
        slot_dest_d[0]  = buf_dest[rd_ptr_q];
        slot_rob_d[0]   = buf_rob[rd_ptr_q];
        ld_pop          = 1'b1;
        n               = 1;
      end
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        idx = (32'(rr_ptr_q) + k) % NUM_FU;
        if (fu_valid_i[FuIdxW'(idx)] && (n < CDB_WIDTH)) begin
          fu_ready_o[FuIdxW'(idx)]     = 1'b1;
          slot_valid_d[SlotIdxW'(n)]   = 1'b1;
          slot_value_d[SlotIdxW'(n)]   = fu_value_i[FuIdxW'(idx)];
          slot_dest_d[SlotIdxW'(n)]    = fu_dest_prf_i[FuIdxW'(idx)];
          slot_rob_d[SlotIdxW'(n)]     = fu_rob_idx_i[FuIdxW'(idx)];
          slot_exc_d[SlotIdxW'(n)]     = fu_exception_i[FuIdxW'(idx)];
          slot_mis_d[SlotIdxW'(n)]     = fu_mispred_i[FuIdxW'(idx)];
          n                            = n + 1;
          last_fu                      = FuIdxW'(idx);
          any_fu                       = 1'b1;
        end
      end
      if (!full && (n < CDB_WIDTH) && (count_q != '0)) begin
        slot_valid_d[SlotIdxW'(n)] = 1'b1;
        slot_value_d[SlotIdxW'(n)] = buf_data[rd_ptr_q];
        slot_dest_d[SlotIdxW'(n)]  = buf_dest[rd_ptr_q];
        slot_rob_d[SlotIdxW'(n)]   = buf_rob[rd_ptr_q];
        ld_pop                     = 1'b1;
      end
    end
    if (any_fu) begin
      rr_ptr_d = (last_fu == FuIdxW'(NUM_FU - 1)) ? '0 : last_fu + FuIdxW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (ld_push) begin
      buf_data[wr_ptr_q] <= ld_data_i;
      buf_dest[wr_ptr_q] <= ld_dest_prf_i;
      buf_rob[wr_ptr_q]  <= ld_rob_idx_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      slot_valid_q <= '0;
      slot_value_q <= '0;
      slot_dest_q  <= '0;
      slot_rob_q   <= '0;
      slot_exc_q   <= '0;
      slot_mis_q   <= '0;
    end else if (flush_i) begin
      // Squash empties the FIFO and slots but keeps round-robin fairness state.
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      slot_valid_q <= '0;
      slot_value_q <= '0;
      slot_dest_q  <= '0;
      slot_rob_q   <= '0;
      slot_exc_q   <= '0;
      slot_mis_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      slot_valid_q <= slot_valid_d;
      slot_value_q <= slot_value_d;
      slot_dest_q  <= slot_dest_d;
      slot_rob_q   <= slot_rob_d;
      slot_exc_q   <= slot_exc_d;
      slot_mis_q   <= slot_mis_d;
      if (ld_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (ld_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(ld_push) - CntW'(ld_pop);
    end
  end

  assign slot_valid_o     = slot_valid_q;
  assign slot_value_o     = slot_value_q;
  assign slot_dest_prf_o  = slot_dest_q;
  assign slot_rob_idx_o   = slot_rob_q;
  assign slot_exception_o = slot_exc_q;
  assign slot_mispred_o   = slot_mis_q;
  assign ld_buf_count_o   = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts grants and
// registered slot contents each cycle; predictions are queued and popped after the edge.
module tb_wb_arbiter;

  localparam int NFU = 6;
  localparam int NSL = 4;
  localparam int DEP = 4;

  typedef struct packed {
    logic [NSL-1:0]         v;
    logic [NSL-1:0][31:0]   val;
    logic [NSL-1:0][6:0]    dest;
    logic [NSL-1:0][5:0]    rob;
    logic [NSL-1:0]         exc;
    logic [NSL-1:0]         mis;
  } slots_t;

  typedef struct packed {
    logic [31:0] d;
    logic [6:0]  t;
    logic [5:0]  r;
  } ld_t;

  logic                      clock;
  logic                      reset;
  logic                      flush;
  logic [NFU-1:0]            fu_valid;
  logic [NFU-1:0]            fu_ready;
  logic [NFU-1:0][31:0]      fu_value;
  logic [NFU-1:0][6:0]       fu_dest;
  logic [NFU-1:0][5:0]       fu_rob;
  logic [NFU-1:0]            fu_exc;
  logic [NFU-1:0]            fu_mis;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [31:0]               ld_data;
  logic [6:0]                ld_dest;
  logic [5:0]                ld_rob;
  logic [NSL-1:0]            slot_valid;
  logic [NSL-1:0][31:0]      slot_value;
  logic [NSL-1:0][6:0]       slot_dest;
  logic [NSL-1:0][5:0]       slot_rob;
  logic [NSL-1:0]            slot_exc;
  logic [NSL-1:0]            slot_mis;
  logic [2:0]                count;

  int checks = 0;
  int errors = 0;

  ld_t    m_q[$];
  slots_t sb[$];
  int     m_rr = 0;

  wb_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .flush_i          (flush),
    .fu_valid_i       (fu_valid),
    .fu_ready_o       (fu_ready),
    .fu_value_i       (fu_value),
    .fu_dest_prf_i    (fu_dest),
    .fu_rob_idx_i     (fu_rob),
    .fu_exception_i   (fu_exc),
    .fu_mispred_i     (fu_mis),
    .ld_valid_i       (ld_valid),
    .ld_ready_o       (ld_ready),
    .ld_data_i        (ld_data),
    .ld_dest_prf_i    (ld_dest),
    .ld_rob_idx_i     (ld_rob),
    .slot_valid_o     (slot_valid),
    .slot_value_o     (slot_value),
    .slot_dest_prf_o  (slot_dest),
    .slot_rob_idx_o   (slot_rob),
    .slot_exception_o (slot_exc),
    .slot_mispred_o   (slot_mis),
    .ld_buf_count_o   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NFU; i++) begin
      fu_value[i] = $urandom;
      fu_dest[i]  = 7'($urandom);
      fu_rob[i]   = 6'($urandom);
      fu_exc[i]   = 1'($urandom);
      fu_mis[i]   = 1'($urandom);
    end
    ld_data = $urandom;
    ld_dest = 7'($urandom);
    ld_rob  = 6'($urandom);
  endtask

  // One cycle: predict at negedge, check combinational grants, compare slots after the edge.
  task automatic step();
    slots_t e;
    slots_t g;
    logic [NFU-1:0] rdy;
    int n;
    int last;
    int idx;
    bit pop;
    bit push;
    bit exp_lr;
    ld_t h;
    @(negedge clock);
    e = '0; rdy = '0; n = 0; last = -1; pop = 0;
    if (!reset && !flush) begin
      if (m_q.size() == DEP) begin
        h = m_q[0];
        e.v[0] = 1'b1; e.val[0] = h.d; e.dest[0] = h.t; e.rob[0] = h.r;
        n = 1; pop = 1;
      end
      for (int k = 0; k < NFU; k++) begin
        idx = (m_rr + k) % NFU;
        if (fu_valid[3'(idx)] && n < NSL) begin
          rdy[3'(idx)]    = 1'b1;
          e.v[2'(n)]      = 1'b1;
          e.val[2'(n)]    = fu_value[3'(idx)];
          e.dest[2'(n)]   = fu_dest[3'(idx)];
          e.rob[2'(n)]    = fu_rob[3'(idx)];
          e.exc[2'(n)]    = fu_exc[3'(idx)];
          e.mis[2'(n)]    = fu_mis[3'(idx)];
          n++;
          last = idx;
        end
      end
      if (!pop && n < NSL && m_q.size() != 0) begin
        h = m_q[0];
        e.v[2'(n)] = 1'b1; e.val[2'(n)] = h.d; e.dest[2'(n)] = h.t; e.rob[2'(n)] = h.r;
        pop = 1;
      end
    end
    exp_lr = !flush && (m_q.size() != DEP);
    check("fu_ready", fu_ready, rdy);
    if (!reset) begin
      check("ld_ready", ld_ready, exp_lr);
      check("count", count, m_q.size());
    end
    push = ld_valid && exp_lr;
    sb.push_back(e);
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_rr = 0;
    end else if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({ld_data, ld_dest, ld_rob});
      if (last >= 0) m_rr = (last + 1) % NFU;
    end
    #1;
    e = sb.pop_front();
    g = {slot_valid, slot_value, slot_dest, slot_rob, slot_exc, slot_mis};
    check("slot_valid", slot_valid, e.v);
    check("slot_payload", g, e);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fu_valid = '0; ld_valid = 1'b0;
    rand_payload();
    step();
    step();
    reset = 1'b0;
    check("rst_slot_valid", slot_valid, 4'b0000);
    check("rst_count", count, 3'd0);
    check("rst_ld_ready", ld_ready, 1'b1);

    // Saturating FUs: two cycles, second one wraps the round-robin pointer.
    fu_valid = '1;
    rand_payload();
    step();
    rand_payload();
    step();

    // Load parked behind full FU traffic, then drained next to FU0/FU1.
    rand_payload();
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    fu_valid = 6'b000011;
    rand_payload();
    step();
    check("two_fu_plus_load", slot_valid, 4'b0111);
    fu_valid = '0;
    step();

    // Loads pile up under saturation until urgent mode frees one per cycle.
    fu_valid = '1;
    ld_valid = 1'b1;
    repeat (5) begin
      rand_payload();
      step();
    end
    ld_valid = 1'b0;
    repeat (2) begin
      rand_payload();
      step();
    end

    // Flush with three loads buffered and FUs active.
    flush = 1'b1;
    rand_payload();
    step();
    flush = 1'b0;
    check("flush_count", count, 3'd0);
    check("flush_slots", slot_valid, 4'b0000);
    rand_payload();
    step();
    fu_valid = '0;
    step();

    // Single load with idle FUs: visible two cycles after the push.
    rand_payload();
    ld_valid = 1'b1;
    ld_data  = 32'hDEADBEEF;
    ld_dest  = 7'd40;
    ld_rob   = 6'd5;
    step();
    ld_valid = 1'b0;
    step();
    check("ld_valid0", slot_valid, 4'b0001);
    check("ld_value0", slot_value[0], 32'hDEADBEEF);
    check("ld_dest0", slot_dest[0], 7'd40);
    check("ld_rob0", slot_rob[0], 6'd5);
    check("ld_flags0", {slot_exc[0], slot_mis[0]}, 2'b00);
    step();

    // Random traffic with sporadic flush and mid-traffic reset.
    repeat (400) begin
      fu_valid = 6'($urandom);
      rand_payload();
      ld_valid = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 24) == 0);
      reset    = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;
    flush = 1'b0;
    fu_valid = '0;
    ld_valid = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
